// File: rtl/led_pkg.sv
// Shared LED-chain types and sizing helpers: channel count, brightness width, full scale, decay counter width.
// Pure declarations: no logic, no latency, no flow control.
package led_pkg;
    localparam int LED_NLEDS = 7;
    localparam int LED_BW    = 8;

    typedef logic [LED_BW-1:0] brightness_t;

    function automatic int led_max(input int bw);
        return (1 << bw) - 1;
    endfunction

    function automatic int led_dcnt_w(input int decay_div);
        return $clog2(decay_div) + 1;
    endfunction
endpackage

// File: rtl/led_fader_if.sv
// LED pattern in / PWM pins out bundle between walker, fader and board pins; free-running, no handshake or backpressure.
// master = pattern source/pin observer, slave = fader.
interface led_fader_if #(
    parameter int NLEDS = led_pkg::LED_NLEDS
);
    logic [NLEDS-1:0] i_led;
    logic [NLEDS-1:0] o_led;
    logic             o_active;

    modport master (output i_led, input  o_led, input  o_active);
    modport slave  (input  i_led, output o_led, output o_active);
endinterface

// File: rtl/led_pwm_channel.sv
// One LED: brightness snap-to-full/decay, optional gamma stage (LED_FADER_GAMMA_EN), registered PWM compare.
// Set-to-pin latency 2 edges (3 with gamma); sampled every clock, no backpressure.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int BW         = LED_BW,
    parameter int DECAY_STEP = 16
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_set,
    input  logic          i_tick,
    input  logic [BW-1:0] i_pwm_cnt,
    output logic          o_led,
    output logic          o_nz
);
    localparam int            MAX  = led_max(BW);
    localparam logic [BW-1:0] STEP = BW'(DECAY_STEP);

    logic [BW-1:0] r_b;
    logic [BW-1:0] w_level;

    // A set wins over a coincident tick; decay saturates at zero.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_b <= '0;
        end else if (i_set) begin
            r_b <= BW'(MAX);
        end else if (i_tick) begin
            r_b <= (r_b > STEP) ? (r_b - STEP) : '0;
        end
    end

`ifdef LED_FADER_GAMMA_EN
    logic [2*BW-1:0] w_bx;
    logic [2*BW-1:0] w_sq;
    logic [BW-1:0]   r_level;

    // +MAX before the shift keeps level(1)=1 and level(MAX)=MAX.
    assign w_bx = {{BW{1'b0}}, r_b};
    assign w_sq = (w_bx * w_bx) + (2*BW)'(MAX);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_level <= '0;
        end else begin
            r_level <= w_sq[2*BW-1:BW];
        end
    end

    assign w_level = r_level;
`else
    assign w_level = r_b;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_led <= 1'b0;
        end else begin
            o_led <= (i_pwm_cnt < w_level);
        end
    end

    assign o_nz = |r_b;
endmodule

// File: rtl/led_fader.sv
// Comet afterglow fader: per-channel brightness with periodic decay, PWM-driven pins; optional gamma via LED_FADER_GAMMA_EN.
// i_led to o_led 2 edges (3 with gamma), o_active 2 edges; no backpressure, input sampled every clock.
module led_fader
    import led_pkg::*;
#(
    parameter int NLEDS      = LED_NLEDS,
    parameter int BW         = LED_BW,
    parameter int DECAY_DIV  = 250_000,
    parameter int DECAY_STEP = 16
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    led_fader_if.slave     bus
);
    localparam int MAX = led_max(BW);
    localparam int DW  = led_dcnt_w(DECAY_DIV);

    if (DECAY_STEP < 1 || DECAY_STEP > MAX) begin : g_bad_step
        $error("led_fader: DECAY_STEP must lie in 1..2^BW-1");
    end
    if (DECAY_DIV < 1) begin : g_bad_div
        $error("led_fader: DECAY_DIV must be at least 1");
    end

    logic [BW-1:0]    r_pwm_cnt;
    logic [DW-1:0]    r_dcnt;
    logic             r_active;
    logic             w_tick;
    logic [NLEDS-1:0] w_led;
    logic [NLEDS-1:0] w_nz;

    assign w_tick = (r_dcnt == DW'(DECAY_DIV - 1));

    // PWM period is MAX clocks so that b=MAX means always on.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pwm_cnt <= '0;
            r_dcnt    <= '0;
            r_active  <= 1'b0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == BW'(MAX - 1)) ? '0 : r_pwm_cnt + 1'b1;
            r_dcnt    <= w_tick ? '0 : r_dcnt + 1'b1;
            r_active  <= |w_nz;
        end
    end

    for (genvar k = 0; k < NLEDS; k++) begin : g_ch
        led_pwm_channel #(
            .BW         (BW),
            .DECAY_STEP (DECAY_STEP)
        ) u_ch (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_set     (bus.i_led[k]),
            .i_tick    (w_tick),
            .i_pwm_cnt (r_pwm_cnt),
            .o_led     (w_led[k]),
            .o_nz      (w_nz[k])
        );
    end

    assign bus.o_led    = w_led;
    assign bus.o_active = r_active;
endmodule

// File: tb/tb_led_fader.sv
// Randomized and directed stimulus for led_fader (BW=4, DECAY_DIV=4, DECAY_STEP=3) against a cycle-count reference model.
module tb_led_fader;
    localparam int N    = 7;
    localparam int BW   = 4;
    localparam int MAX  = 15;
    localparam int DIV  = 4;
    localparam int STEP = 3;
`ifdef LED_FADER_GAMMA_EN
    localparam int LAT  = 2;
`else
    localparam int LAT  = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    // Model state: edges since reset, brightness and (gamma) registered level per channel.
    int n = 0;
    int mb[N];
    int ml[N];

    led_fader_if #(.NLEDS(N)) bus ();

    led_fader #(
        .NLEDS      (N),
        .BW         (BW),
        .DECAY_DIV  (DIV),
        .DECAY_STEP (STEP)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic int gamma_of(input int b);
        return (b * b + MAX) / (MAX + 1);
    endfunction

    task automatic model_reset();
        n = 0;
        for (int k = 0; k < N; k++) begin
            mb[k] = 0;
            ml[k] = 0;
        end
    endtask

    task automatic check_bits(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
        end
    endtask

    // One clock: drive pattern, advance model at the edge, compare at the falling edge.
    task automatic step(input logic [N-1:0] led);
        logic [N-1:0] eo;
        logic         ea;
        int           lvl;
        bus.i_led = led;
        @(posedge clk);
        eo = '0;
        ea = 1'b0;
        for (int k = 0; k < N; k++) begin
`ifdef LED_FADER_GAMMA_EN
            lvl = ml[k];
`else
            lvl = mb[k];
`endif
            eo[k] = ((n % MAX) < lvl);
            if (mb[k] != 0) ea = 1'b1;
            ml[k] = gamma_of(mb[k]);
            if (led[k]) mb[k] = MAX;
            else if ((n % DIV) == DIV - 1) mb[k] = (mb[k] > STEP) ? mb[k] - STEP : 0;
        end
        n++;
        @(negedge clk);
        check_bits("o_led", bus.o_led, eo);
        check_bits("o_active", N'(bus.o_active), N'(ea));
    endtask

    initial begin
        logic [N-1:0] pat;
        int           guard;
        bus.i_led = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check_bits("reset_o_led", bus.o_led, '0);
        check_bits("reset_o_active", N'(bus.o_active), '0);
        rst_n = 1'b1;

        repeat (100) step('0);

        step(7'b000_0001);
        repeat (30) step('0);

        for (int i = 0; i < 44; i++) begin
            step(7'b000_1000);
            if (i >= LAT) check_bits("hold_led3", N'(bus.o_led[3]), N'(1));
        end
        repeat (30) step('0);

        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < N; k++) repeat (8) step(N'(1 << k));
            for (int k = N - 2; k > 0; k--) repeat (8) step(N'(1 << k));
        end
        repeat (40) step('0);

        for (int i = 0; i < 300; i++) begin
            pat = N'($urandom);
            step(($urandom_range(0, 3) == 0) ? pat : '0);
        end
        repeat (40) step('0);

        // Fade channel 2 down to 9, then reset asynchronously between edges.
        step(7'b000_0100);
        guard = 0;
        while (mb[2] != 9 && guard < 40) begin
            step('0);
            guard++;
        end
        vecs++;
        assert (mb[2] == 9) else begin
            errs++;
            $error("FAIL fade_to_9 observed=%0d expected=9", mb[2]);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_bits("arst_o_led", bus.o_led, '0);
        check_bits("arst_o_active", N'(bus.o_active), '0);
        check_bits("arst_b2", N'(dut.g_ch[2].u_ch.r_b), '0);
        check_bits("arst_b0", N'(dut.g_ch[0].u_ch.r_b), '0);
        @(posedge clk);
        @(negedge clk);
        check_bits("arst_hold_o_led", bus.o_led, '0);
        rst_n = 1'b1;
        repeat (30) step('0);
        step(7'b100_0010);
        repeat (25) step('0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
